// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM access arbiter.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    DRAIN   = 2'd1,
    VB_IDLE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_GPU  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding buffered CPU writes as {addr,data} words.
// The caller never pushes when full nor pops when empty.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/vram_access_arbiter.sv
// Shares the single-port VRAM between renderer reads and buffered CPU writes;
// CPU writes can be held back to vertical blank for tear-free updates.
module vram_access_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int FIFO_DEPTH       = 4,
  parameter int COMMIT_IN_VBLANK = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vblank,
  input  logic                          gpu_rd_req,
  input  logic [ADDR_W-1:0]             gpu_rd_addr,
  output logic                          gpu_rd_valid,
  output logic [DATA_W-1:0]             gpu_rd_data,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [DATA_W-1:0]             cpu_wr_data,
  output logic                          vram_en,
  output logic                          vram_we,
  output logic [ADDR_W-1:0]             vram_addr,
  output logic [DATA_W-1:0]             vram_wdata,
  input  logic [DATA_W-1:0]             vram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam bit VB_ONLY = (COMMIT_IN_VBLANK != 0);

  arb_state_t state, state_next;
  grant_t     grant;

  logic [LVL_W-1:0]         level;
  logic [LVL_W-1:0]         level_after_pop;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0]        fifo_addr;
  logic [DATA_W-1:0]        fifo_data;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  logic                     drain_ok;
  logic                     overrun_set;

  // Ready is held low during reset so nothing is accepted until release.
  assign cpu_wr_ready = rst_n & (level < DEPTH_L);
  assign push         = cpu_wr_valid & cpu_wr_ready;
  assign fifo_empty   = (level == '0);
  assign drain_ok     = !VB_ONLY || (state == DRAIN);
  assign pop          = (grant == GNT_CPU);
  assign level_after_pop = level - LVL_W'(pop);

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({cpu_wr_addr, cpu_wr_data}),
    .rdata (fifo_rdata),
    .level (level)
  );

  assign {fifo_addr, fifo_data} = fifo_rdata;

  always_comb begin
    grant = GNT_NONE;
    if (gpu_rd_req)                    grant = GNT_GPU;
    else if (!fifo_empty && drain_ok)  grant = GNT_CPU;
  end

  always_comb begin
    state_next  = state;
    overrun_set = 1'b0;
    unique case (state)
      ACTIVE: begin
        if (vblank) state_next = fifo_empty ? VB_IDLE : DRAIN;
      end
      DRAIN: begin
        if (!vblank) begin
          state_next  = ACTIVE;
          overrun_set = VB_ONLY && (level_after_pop != '0);
        end else if (level_after_pop == '0 && !push) begin
          state_next = VB_IDLE;
        end
      end
      VB_IDLE: begin
        if (!vblank)                  state_next = ACTIVE;
        else if (push || !fifo_empty) state_next = DRAIN;
      end
      default: state_next = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACTIVE;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (overrun_set) overrun <= 1'b1;
    end
  end

  // VRAM strobes lag the grant by one cycle; read valid follows one more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_en      <= 1'b0;
      vram_we      <= 1'b0;
      vram_addr    <= '0;
      vram_wdata   <= '0;
      gpu_rd_valid <= 1'b0;
    end else begin
      vram_en      <= (grant != GNT_NONE);
      vram_we      <= (grant == GNT_CPU);
      gpu_rd_valid <= vram_en & ~vram_we;
      if (grant == GNT_GPU) begin
        vram_addr <= gpu_rd_addr;
      end else if (grant == GNT_CPU) begin
        vram_addr  <= fifo_addr;
        vram_wdata <= fifo_data;
      end
    end
  end

  assign gpu_rd_data = vram_rdata;
  assign fifo_level  = level;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbiter and a behavioural VRAM.
module tb_vram_access_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          vblank;
  logic          gpu_rd_req;
  logic [AW-1:0] gpu_rd_addr;
  logic          gpu_rd_valid;
  logic [DW-1:0] gpu_rd_data;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          vram_en;
  logic          vram_we;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata;
  logic [2:0]    fifo_level;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;

  vram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .COMMIT_IN_VBLANK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank),
    .gpu_rd_req(gpu_rd_req), .gpu_rd_addr(gpu_rd_addr),
    .gpu_rd_valid(gpu_rd_valid), .gpu_rd_data(gpu_rd_data),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .fifo_level(fifo_level), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural VRAM: unwritten locations read back as addr[7:0].
  logic [DW-1:0] vmem [int];
  initial vram_rdata = '0;
  always @(posedge clk) begin
    if (vram_en) begin
      if (vram_we) vmem[int'(vram_addr)] = vram_wdata;
      else vram_rdata <= vmem.exists(int'(vram_addr)) ? vmem[int'(vram_addr)] : vram_addr[7:0];
    end
  end

  // Reference model: pending writes as a queue, a memory image, and the
  // blanking window rules (0 = active video, 1 = draining, 2 = blank idle).
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           q[$];
  logic [DW-1:0] mmem [int];
  int            m_st;
  bit            m_ovr;
  logic          e_en, e_we, e_valid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rd1, e_rd2;

  function automatic logic [DW-1:0] mread(logic [AW-1:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : a[7:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_st = 0; m_ovr = 0;
    e_en = 0; e_we = 0; e_valid = 0;
    e_addr = '0; e_wdata = '0; e_rd1 = '0; e_rd2 = '0;
  endtask

  // Advance one clock: predict from the inputs now applied, then sample #1 after the edge.
  task automatic cycle();
    int   lvl;
    int   after;
    bit   push, gg, gc;
    wr_t  e;
    logic n_en, n_we, n_valid;
    logic [AW-1:0] n_addr;
    logic [DW-1:0] n_wdata, n_rd1, n_rd2;
    lvl  = q.size();
    push = cpu_wr_valid && (lvl < DEPTH);
    gg   = gpu_rd_req;
    gc   = !gg && (lvl != 0) && (m_st == 1);
    n_valid = e_en && !e_we;
    n_rd2   = e_rd1;
    n_rd1   = e_rd1;
    n_addr  = e_addr;
    n_wdata = e_wdata;
    n_en    = gg || gc;
    n_we    = gc;
    if (gg) begin
      n_addr = gpu_rd_addr;
      n_rd1  = mread(gpu_rd_addr);
    end
    if (gc) begin
      e = q.pop_front();
      mmem[int'(e.a)] = e.d;
      n_addr  = e.a;
      n_wdata = e.d;
    end
    after = q.size();
    case (m_st)
      0: if (vblank) m_st = (lvl != 0) ? 1 : 2;
      1: if (!vblank) begin
           if (after != 0) m_ovr = 1;
           m_st = 0;
         end else if (after == 0 && !push) m_st = 2;
      default: if (!vblank) m_st = 0; else if (push || lvl != 0) m_st = 1;
    endcase
    if (push) q.push_back({cpu_wr_addr, cpu_wr_data});
    @(posedge clk);
    #1;
    e_en = n_en; e_we = n_we; e_valid = n_valid;
    e_addr = n_addr; e_wdata = n_wdata; e_rd1 = n_rd1; e_rd2 = n_rd2;
  endtask

  task automatic idle_inputs();
    gpu_rd_req = 0; gpu_rd_addr = '0;
    cpu_wr_valid = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; vblank = 0;
    idle_inputs();
    model_reset();
    #2;
    n_cmp++; if (vram_en !== 1'b0 || vram_we !== 1'b0) begin n_bad++; $display("FAIL rst_en_we: got %0b%0b want 00", vram_en, vram_we); end
    n_cmp++; if (vram_addr !== '0 || vram_wdata !== '0) begin n_bad++; $display("FAIL rst_addr_data: got %h/%h want 0/0", vram_addr, vram_wdata); end
    n_cmp++; if (gpu_rd_valid !== 1'b0 || fifo_level !== 3'd0 || overrun !== 1'b0) begin n_bad++; $display("FAIL rst_valid_lvl_ovr: got %0b/%0d/%0b want 0/0/0", gpu_rd_valid, fifo_level, overrun); end
    n_cmp++; if (cpu_wr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %0b want 0", cpu_wr_ready); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if (cpu_wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_high: got %0b want 1", cpu_wr_ready); end
  endtask

  task automatic test_read_latency();
    vblank = 0;
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      gpu_rd_req  = (k < 3);
      gpu_rd_addr = AW'(16 + k);
      cycle();
      n_cmp++; if (vram_en !== (k < 3) || vram_we !== 1'b0) begin n_bad++; $display("FAIL rd_en%0d: got en=%0b we=%0b want en=%0b we=0", k, vram_en, vram_we, (k < 3)); end
      if (k < 3) begin
        n_cmp++; if (vram_addr !== AW'(16 + k)) begin n_bad++; $display("FAIL rd_addr%0d: got %h want %h", k, vram_addr, 16 + k); end
      end
      n_cmp++; if (gpu_rd_valid !== (k >= 1 && k <= 3)) begin n_bad++; $display("FAIL rd_valid%0d: got %0b want %0b", k, gpu_rd_valid, (k >= 1 && k <= 3)); end
      if (k >= 1 && k <= 3) begin
        n_cmp++; if (gpu_rd_data !== DW'(16 + k - 1)) begin n_bad++; $display("FAIL rd_data%0d: got %h want %h", k, gpu_rd_data, 16 + k - 1); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_deferred_commit();
    vblank = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = AW'(256 + i); cpu_wr_data = DW'(8'hA1 + i);
      cycle();
      n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL dc_hold%0d: got we=%0b want 0", i, vram_we); end
    end
    cpu_wr_valid = 0;
    n_cmp++; if (fifo_level !== 3'd3) begin n_bad++; $display("FAIL dc_level3: got %0d want 3", fifo_level); end
    vblank = 1;
    cycle();
    n_cmp++; if (vram_we !== 1'b0) begin n_bad++; $display("FAIL dc_first_vb: got we=%0b want 0", vram_we); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (vram_en !== 1'b1 || vram_we !== 1'b1 || vram_addr !== AW'(256 + i) || vram_wdata !== DW'(8'hA1 + i)) begin
        n_bad++; $display("FAIL dc_commit%0d: got en=%0b we=%0b %h<-%h want 1 1 %h<-%h", i, vram_en, vram_we, vram_addr, vram_wdata, 256 + i, 8'hA1 + i);
      end
    end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL dc_level0: got %0d want 0", fifo_level); end
    cycle();
    n_cmp++; if (vram_en !== 1'b0) begin n_bad++; $display("FAIL dc_idle_after: got en=%0b want 0", vram_en); end
    vblank = 0;
    cycle();
  endtask

  task automatic test_backpressure();
    int got;
    vblank = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cpu_wr_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready%0d: got %0b want 1", i, cpu_wr_ready); end
      cpu_wr_valid = 1; cpu_wr_addr = AW'(512 + i); cpu_wr_data = DW'(8'hB0 + i);
      cycle();
    end
    cpu_wr_addr = AW'(516); cpu_wr_data = 8'hB4;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (cpu_wr_ready !== 1'b0 || fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_full%0d: got ready=%0b lvl=%0d want 0/4", i, cpu_wr_ready, fifo_level); end
      cycle();
    end
    vblank = 1;
    cycle();
    n_cmp++; if (cpu_wr_ready !== 1'b0 || vram_we !== 1'b0) begin n_bad++; $display("FAIL bp_vb_entry: got ready=%0b we=%0b want 0/0", cpu_wr_ready, vram_we); end
    cycle();
    n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(512) || cpu_wr_ready !== 1'b1 || fifo_level !== 3'd3) begin
      n_bad++; $display("FAIL bp_first_pop: got we=%0b addr=%h ready=%0b lvl=%0d want 1 200 1 3", vram_we, vram_addr, cpu_wr_ready, fifo_level);
    end
    cycle();
    cpu_wr_valid = 0;
    n_cmp++; if (vram_addr !== AW'(513) || fifo_level !== 3'd3) begin n_bad++; $display("FAIL bp_fifth_in: got addr=%h lvl=%0d want 201/3", vram_addr, fifo_level); end
    got = 2;
    for (int t = 0; t < 12 && got < 5; t++) begin
      cycle();
      if (vram_we === 1'b1) begin
        n_cmp++; if (vram_addr !== AW'(512 + got) || vram_wdata !== DW'(8'hB0 + got)) begin
          n_bad++; $display("FAIL bp_order%0d: got %h<-%h want %h<-%h", got, vram_addr, vram_wdata, 512 + got, 8'hB0 + got);
        end
        got++;
      end
    end
    n_cmp++; if (got != 5 || fifo_level !== 3'd0) begin n_bad++; $display("FAIL bp_drain_done: got %0d writes lvl=%0d want 5/0", got, fifo_level); end
    vblank = 0;
    cycle();
  endtask

  task automatic test_priority();
    vblank = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = AW'(768 + i); cpu_wr_data = DW'(8'hC1 + i);
      cycle();
    end
    cpu_wr_valid = 0;
    vblank = 1;
    cycle();
    gpu_rd_req = 1; gpu_rd_addr = AW'(256);
    cycle();
    gpu_rd_req = 0;
    n_cmp++; if (vram_en !== 1'b1 || vram_we !== 1'b0 || vram_addr !== AW'(256)) begin n_bad++; $display("FAIL pr_gpu_wins: got en=%0b we=%0b addr=%h want 1 0 100", vram_en, vram_we, vram_addr); end
    cycle();
    n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(768)) begin n_bad++; $display("FAIL pr_resume0: got we=%0b addr=%h want 1 300", vram_we, vram_addr); end
    n_cmp++; if (gpu_rd_valid !== 1'b1 || gpu_rd_data !== 8'hA1) begin n_bad++; $display("FAIL pr_rd_data: got valid=%0b data=%h want 1 a1", gpu_rd_valid, gpu_rd_data); end
    cycle();
    n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(769) || gpu_rd_valid !== 1'b0) begin n_bad++; $display("FAIL pr_resume1: got we=%0b addr=%h valid=%0b want 1 301 0", vram_we, vram_addr, gpu_rd_valid); end
    vblank = 0;
    cycle();
  endtask

  task automatic test_overrun();
    vblank = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = AW'(1024 + i); cpu_wr_data = DW'(8'hD0 + i);
      cycle();
    end
    cpu_wr_valid = 0;
    vblank = 1;
    cycle();
    cycle();
    n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(1024) || overrun !== 1'b0) begin n_bad++; $display("FAIL ov_first: got we=%0b addr=%h ovr=%0b want 1 400 0", vram_we, vram_addr, overrun); end
    vblank = 0;
    cycle();
    n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(1025)) begin n_bad++; $display("FAIL ov_second: got we=%0b addr=%h want 1 401", vram_we, vram_addr); end
    n_cmp++; if (overrun !== 1'b1 || fifo_level !== 3'd2) begin n_bad++; $display("FAIL ov_flag: got ovr=%0b lvl=%0d want 1/2", overrun, fifo_level); end
    cycle();
    cycle();
    n_cmp++; if (vram_we !== 1'b0 || fifo_level !== 3'd2) begin n_bad++; $display("FAIL ov_kept: got we=%0b lvl=%0d want 0/2", vram_we, fifo_level); end
    vblank = 1;
    cycle();
    for (int i = 2; i < 4; i++) begin
      cycle();
      n_cmp++; if (vram_we !== 1'b1 || vram_addr !== AW'(1024 + i) || vram_wdata !== DW'(8'hD0 + i)) begin
        n_bad++; $display("FAIL ov_next_vb%0d: got we=%0b %h<-%h want 1 %h<-%h", i, vram_we, vram_addr, vram_wdata, 1024 + i, 8'hD0 + i);
      end
    end
    n_cmp++; if (fifo_level !== 3'd0 || overrun !== 1'b1) begin n_bad++; $display("FAIL ov_sticky: got lvl=%0d ovr=%0b want 0/1", fifo_level, overrun); end
    vblank = 0;
    cycle();
  endtask

  task automatic test_reset_mid_drain();
    vblank = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1; cpu_wr_addr = AW'(1280 + i); cpu_wr_data = DW'(8'hE0 + i);
      cycle();
    end
    cpu_wr_valid = 0;
    vblank = 1;
    cycle();
    cycle();
    gpu_rd_req = 1; gpu_rd_addr = AW'(16);
    cycle();
    #2;
    rst_n = 0;
    #1;
    n_cmp++; if (vram_en !== 1'b0 || vram_we !== 1'b0 || vram_addr !== '0 || vram_wdata !== '0) begin
      n_bad++; $display("FAIL mr_vram_zero: got en=%0b we=%0b addr=%h wdata=%h want all 0", vram_en, vram_we, vram_addr, vram_wdata);
    end
    n_cmp++; if (gpu_rd_valid !== 1'b0 || fifo_level !== 3'd0 || overrun !== 1'b0 || cpu_wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL mr_status_zero: got valid=%0b lvl=%0d ovr=%0b ready=%0b want 0 0 0 0", gpu_rd_valid, fifo_level, overrun, cpu_wr_ready);
    end
    idle_inputs();
    vblank = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (vram_we !== 1'b0 || gpu_rd_valid !== 1'b0 || fifo_level !== 3'd0) begin
        n_bad++; $display("FAIL mr_after%0d: got we=%0b valid=%0b lvl=%0d want 0 0 0", i, vram_we, gpu_rd_valid, fifo_level);
      end
    end
  endtask

  task automatic test_random();
    vblank = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) vblank = ~vblank;
      gpu_rd_req   = ($urandom_range(0, 9) < 3);
      gpu_rd_addr  = AW'(256 + $urandom_range(0, 15));
      cpu_wr_valid = ($urandom_range(0, 1) == 1);
      cpu_wr_addr  = AW'(256 + $urandom_range(0, 15));
      cpu_wr_data  = DW'($urandom);
      cycle();
      n_cmp++; if (vram_en !== e_en || vram_we !== e_we) begin n_bad++; $display("FAIL rnd_en_we@%0d: got %0b%0b want %0b%0b", i, vram_en, vram_we, e_en, e_we); end
      n_cmp++; if (vram_addr !== e_addr || vram_wdata !== e_wdata) begin n_bad++; $display("FAIL rnd_addr_data@%0d: got %h/%h want %h/%h", i, vram_addr, vram_wdata, e_addr, e_wdata); end
      n_cmp++; if (gpu_rd_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, gpu_rd_valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if (gpu_rd_data !== e_rd2) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", i, gpu_rd_data, e_rd2); end
      end
      n_cmp++; if (fifo_level !== 3'(q.size()) || cpu_wr_ready !== (q.size() < DEPTH)) begin
        n_bad++; $display("FAIL rnd_level@%0d: got lvl=%0d ready=%0b want %0d/%0b", i, fifo_level, cpu_wr_ready, q.size(), (q.size() < DEPTH));
      end
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rnd_overrun@%0d: got %0b want %0b", i, overrun, m_ovr); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_deferred_commit();
    test_backpressure();
    test_priority();
    test_overrun();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Shares the single-port, synchronous-read VRAM between the pixel renderer (read port) and CPU-side writes (write port).
- Sequenced by the blanking signal from the video timing generator.
- CPU writes are buffered in a small FIFO. They are committed either in any renderer-idle cycle, or only during vertical blank for tear-free updates.
- Sits between the timing generator, the renderer fetch logic and the VRAM macro.

Parameters:
- ADDR_W, 15, VRAM address width.
- DATA_W, 8, VRAM data width.
- FIFO_DEPTH, 4, CPU write buffer entries (power of two, ≥2).
- COMMIT_IN_VBLANK, 1: 1 = writes drained only while vblank=1; 0 = writes drained in any cycle without a renderer request.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking (from timing generator)
- gpu_rd_req  in  1  renderer read request, single-cycle per access
- gpu_rd_addr  in  ADDR_W  renderer read address
- gpu_rd_valid  out  1  read data valid
- gpu_rd_data  out  DATA_W  read data (= vram_rdata)
- cpu_wr_valid  in  1  CPU write offered
- cpu_wr_ready  out  1  write accepted when valid&ready
- cpu_wr_addr  in  ADDR_W  write address
- cpu_wr_data  in  DATA_W  write data
- vram_en  out  1  VRAM access strobe
- vram_we  out  1  VRAM write enable
- vram_addr  out  ADDR_W  VRAM address
- vram_wdata  out  DATA_W  VRAM write data
- vram_rdata  in  DATA_W  VRAM read data, valid 1 cycle after en&!we
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- overrun  out  1  sticky: vblank fell with writes pending (COMMIT_IN_VBLANK=1 only)

Behaviour:
- Reset (async, rst_n=0):
  - vram_en=0, vram_we=0, vram_addr=0, vram_wdata=0.
  - gpu_rd_valid=0, fifo_level=0, overrun=0, state=ACTIVE.
  - cpu_wr_ready=1 once rst_n=1.
  - Reset mid-operation discards FIFO contents and any in-flight read; no valid is produced for it.
- FIFO:
  - Push on cpu_wr_valid&cpu_wr_ready.
  - cpu_wr_ready = (level < FIFO_DEPTH), combinational from level. A same-cycle pop does not raise ready.
  - Push and pop in the same cycle leave level unchanged.
  - Ordering is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- Grant, evaluated each cycle, fixed priority:
  1. gpu_rd_req=1 → GPU grant. The renderer always wins, including during vblank.
  2. Otherwise, FIFO non-empty and drain permitted → CPU grant, pop one entry.
  3. Otherwise, no grant.
- Drain permitted = (state==DRAIN) when COMMIT_IN_VBLANK=1; = 1 when COMMIT_IN_VBLANK=0.
- Outputs are registered:
  - A grant in cycle N drives vram_en/we/addr/wdata in cycle N+1.
  - For a GPU grant, vram_rdata arrives at N+2; gpu_rd_valid=1 in N+2 only.
  - Read latency req→valid is exactly 2 cycles. Back-to-back reqs give back-to-back valids.
  - Idle cycle: vram_en=0, vram_we=0; addr and wdata hold their last value.
- State machine (used when COMMIT_IN_VBLANK=1; tracked always):
  - ACTIVE: vblank=1 → DRAIN if level≠0, else VB_IDLE.
  - DRAIN: vblank=0 → ACTIVE; also set overrun if level≠0 (counting this cycle's pop). level reaches 0 with vblank=1 → VB_IDLE.
  - VB_IDLE: vblank=0 → ACTIVE; push received → DRAIN.
- Writes pending at vblank fall stay queued for the next vblank; they are never dropped.
- overrun clears only on reset.
- vblank rising in the same cycle as a gpu_rd_req: the GPU is granted, and draining starts the next free cycle.

Decomposition:
- Package vram_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - state encoding ACTIVE=2'd0, DRAIN=2'd1, VB_IDLE=2'd2;
  - grant encoding NONE/GPU/CPU.
- One sub-module, vram_wr_fifo: parameterised synchronous FIFO storing {addr,data}, with level output, async active-low reset.

Test Plan:
- Read latency: vblank=0, gpu_rd_req at cycles 10,11,12 with addr 0x0010..0x0012, VRAM model returns addr[7:0] → vram_en at 11–13; gpu_rd_valid at 12–14 with data 0x10,0x11,0x12.
- Deferred commit (COMMIT_IN_VBLANK=1): push 3 writes (0x0100←0xA1, 0x0101←0xA2, 0x0102←0xA3) while vblank=0 → no vram_we, fifo_level=3; raise vblank → three consecutive vram_we cycles in order; level returns 0; state VB_IDLE.
- Full/backpressure: hold cpu_wr_valid with vblank=0 → 4 accepted, cpu_wr_ready=0 at level 4; 5th write accepted only the cycle after the first drain pop in vblank.
- Priority and collision: vblank=1, FIFO holds 2 writes, gpu_rd_req pulsed once → that cycle is a GPU read; writes resume the next cycles; the read returns correct data 2 cycles later.
- Overrun: 4 writes queued, vblank high for 2 cycles only → 2 writes committed, overrun=1, level=2; next vblank drains the remaining 2.
- Async reset mid-drain: assert rst_n=0 between clock edges during DRAIN → all outputs zero immediately; after release, level=0, no stale vram_we, no gpu_rd_valid.
